// File: rtl/nw_traceback.sv
// Needleman-Wunsch traceback engine: walks the direction matrix from
// (len_a, len_b) back to (0,0) and streams one aligned column per step
// in reverse alignment order.
module nw_traceback #(
  parameter int unsigned IDX_W  = 7,
  parameter int unsigned CHAR_W = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [IDX_W-1:0]    len_a,
  input  logic [IDX_W-1:0]    len_b,
  output logic                rd_en,
  output logic [IDX_W-1:0]    rd_i,
  output logic [IDX_W-1:0]    rd_j,
  output logic [IDX_W-1:0]    char_a_addr,
  output logic [IDX_W-1:0]    char_b_addr,
  input  logic [2:0]          rd_symbol,
  input  logic [CHAR_W-1:0]   char_a,
  input  logic [CHAR_W-1:0]   char_b,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [CHAR_W-1:0]   out_a,
  output logic                gap_a,
  output logic [CHAR_W-1:0]   out_b,
  output logic                gap_b,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic [IDX_W:0]      out_count
);

  localparam int unsigned CNT_W = IDX_W + 1;

  localparam logic [2:0] SYM_LEFT = 3'b100;
  localparam logic [2:0] SYM_UP   = 3'b010;
  localparam logic [2:0] SYM_DIAG = 3'b001;

  typedef enum logic [2:0] {
    S_IDLE,
    S_READ,
    S_WAIT,
    S_EMIT,
    S_DONE
  } state_e;

  state_e              state_q;
  logic [IDX_W-1:0]    i_q, j_q;
  logic [IDX_W-1:0]    ca_q, cb_q;
  logic [2:0]          mv_q;
  logic                rd_en_q;
  logic                out_valid_q;
  logic [CHAR_W-1:0]   out_a_q, out_b_q;
  logic                gap_a_q, gap_b_q;
  logic                busy_q, done_q, err_q;
  logic [CNT_W-1:0]    cnt_q;

  logic [2:0]          move_d;
  logic                legal_d;
  logic [IDX_W-1:0]    i_d, j_d;

  // Character RAM address for a 1-based index: one below it, clamped at 0.
  function automatic logic [IDX_W-1:0] prev_addr(input logic [IDX_W-1:0] x);
    return (x == '0) ? '0 : x - IDX_W'(1);
  endfunction

  // Move decode (edge cells force the move) and post-transfer indices.
  always_comb begin
    move_d  = rd_symbol;
    if (i_q == '0) begin
      move_d = SYM_LEFT;
    end else if (j_q == '0) begin
      move_d = SYM_UP;
    end
    legal_d = (move_d == SYM_LEFT) || (move_d == SYM_UP) || (move_d == SYM_DIAG);
    i_d     = i_q;
    j_d     = j_q;
    if ((mv_q == SYM_DIAG) || (mv_q == SYM_UP)) begin
      i_d = i_q - IDX_W'(1);
    end
    if ((mv_q == SYM_DIAG) || (mv_q == SYM_LEFT)) begin
      j_d = j_q - IDX_W'(1);
    end
  end

  // Traceback state machine with registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      i_q         <= '0;
      j_q         <= '0;
      ca_q        <= '0;
      cb_q        <= '0;
      mv_q        <= '0;
      rd_en_q     <= 1'b0;
      out_valid_q <= 1'b0;
      out_a_q     <= '0;
      out_b_q     <= '0;
      gap_a_q     <= 1'b0;
      gap_b_q     <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      cnt_q       <= '0;
    end else begin
      rd_en_q <= 1'b0;
      done_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            i_q    <= len_a;
            j_q    <= len_b;
            ca_q   <= prev_addr(len_a);
            cb_q   <= prev_addr(len_b);
            err_q  <= 1'b0;
            cnt_q  <= '0;
            busy_q <= 1'b1;
            if ((len_a == '0) && (len_b == '0)) begin
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end else begin
              rd_en_q <= 1'b1;
              state_q <= S_READ;
            end
          end
        end
        S_READ: begin
          state_q <= S_WAIT;
        end
        S_WAIT: begin
          if (!legal_d) begin
            err_q   <= 1'b1;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end else begin
            mv_q        <= move_d;
            out_valid_q <= 1'b1;
            out_a_q     <= (move_d == SYM_LEFT) ? '0 : char_a;
            gap_a_q     <= (move_d == SYM_LEFT);
            out_b_q     <= (move_d == SYM_UP) ? '0 : char_b;
            gap_b_q     <= (move_d == SYM_UP);
            state_q     <= S_EMIT;
          end
        end
        S_EMIT: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            cnt_q       <= cnt_q + CNT_W'(1);
            i_q         <= i_d;
            j_q         <= j_d;
            ca_q        <= prev_addr(i_d);
            cb_q        <= prev_addr(j_d);
            if ((i_d == '0) && (j_d == '0)) begin
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end else begin
              rd_en_q <= 1'b1;
              state_q <= S_READ;
            end
          end
        end
        S_DONE: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign rd_en       = rd_en_q;
  assign rd_i        = i_q;
  assign rd_j        = j_q;
  assign char_a_addr = ca_q;
  assign char_b_addr = cb_q;
  assign out_valid   = out_valid_q;
  assign out_a       = out_a_q;
  assign gap_a       = gap_a_q;
  assign out_b       = out_b_q;
  assign gap_b       = gap_b_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign err         = err_q;
  assign out_count   = cnt_q;

endmodule

// File: tb/tb_nw_traceback.sv
// Bench for nw_traceback: directed and random tracebacks checked against
// a matrix-walk reference model; the bench also plays the three RAMs.
module tb_nw_traceback;

  localparam int unsigned IDX_W  = 7;
  localparam int unsigned CHAR_W = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              rst_n;
  logic              start;
  logic [IDX_W-1:0]  len_a, len_b;
  logic              rd_en;
  logic [IDX_W-1:0]  rd_i, rd_j, char_a_addr, char_b_addr;
  logic [2:0]        rd_symbol;
  logic [CHAR_W-1:0] char_a, char_b;
  logic              out_valid, out_ready;
  logic [CHAR_W-1:0] out_a, out_b;
  logic              gap_a, gap_b, busy, done, err;
  logic [IDX_W:0]    out_count;

  nw_traceback #(.IDX_W(IDX_W), .CHAR_W(CHAR_W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .len_a(len_a), .len_b(len_b),
    .rd_en(rd_en), .rd_i(rd_i), .rd_j(rd_j),
    .char_a_addr(char_a_addr), .char_b_addr(char_b_addr),
    .rd_symbol(rd_symbol), .char_a(char_a), .char_b(char_b),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_a(out_a), .gap_a(gap_a), .out_b(out_b), .gap_b(gap_b),
    .busy(busy), .done(done), .err(err), .out_count(out_count)
  );

  logic [2:0]        sym_mem [0:127][0:127];
  logic [CHAR_W-1:0] mem_a [0:127];
  logic [CHAR_W-1:0] mem_b [0:127];

  // Single-port RAMs with one cycle of read latency.
  always @(posedge clk) begin
    if (rd_en) begin
      rd_symbol <= sym_mem[rd_i][rd_j];
      char_a    <= mem_a[char_a_addr];
      char_b    <= mem_b[char_b_addr];
    end
  end

  typedef struct {
    logic [CHAR_W-1:0] a;
    logic              ga;
    logic [CHAR_W-1:0] b;
    logic              gb;
  } col_t;

  col_t exp_cols[$];
  int   exp_ri[$];
  int   exp_rj[$];

  int vecs = 0;
  int miss = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      miss++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mems();
    for (int r = 0; r < 128; r++) begin
      mem_a[r] = '0;
      mem_b[r] = '0;
      for (int c = 0; c < 128; c++) sym_mem[r][c] = 3'b001;
    end
  endtask

  // Reference walk of the matrix, then drive one traceback and check it.
  task automatic run(input int la, input int lb, input int stall_in, input bit rnd);
    int i, j, stall, cyc, first_rd, first_ov, last_rd, last_xfer, exp_done, ncols, ri, rj;
    bit e, held, seen;
    logic [2:0] s;
    col_t c, hv, got;
    exp_cols.delete(); exp_ri.delete(); exp_rj.delete();
    i = la; j = lb; e = 0;
    while ((i != 0 || j != 0) && !e) begin
      exp_ri.push_back(i); exp_rj.push_back(j);
      if (i == 0) s = 3'b100;
      else if (j == 0) s = 3'b010;
      else s = sym_mem[i][j];
      if (s == 3'b001) begin
        c.a = mem_a[i-1]; c.ga = 0; c.b = mem_b[j-1]; c.gb = 0; i--; j--;
        exp_cols.push_back(c);
      end else if (s == 3'b010) begin
        c.a = mem_a[i-1]; c.ga = 0; c.b = '0; c.gb = 1; i--;
        exp_cols.push_back(c);
      end else if (s == 3'b100) begin
        c.a = '0; c.ga = 1; c.b = mem_b[j-1]; c.gb = 0; j--;
        exp_cols.push_back(c);
      end else begin
        e = 1;
      end
    end
    ncols = exp_cols.size();

    stall = stall_in;
    first_rd = -1; first_ov = -1; last_rd = 0; last_xfer = 0;
    held = 0; seen = 0; hv = '{default: '0};
    @(negedge clk);
    start = 1'b1; len_a = IDX_W'(la); len_b = IDX_W'(lb); out_ready = 1'b1;
    for (cyc = 1; cyc <= 3000; cyc++) begin
      @(negedge clk);
      start = 1'b0;
      if (cyc == 1) begin
        chk("err_clear", err, 0);
        chk("busy_start", busy, 1);
      end
      if (rd_en) begin
        last_rd = cyc;
        if (first_rd < 0) first_rd = cyc;
        if (exp_ri.size() == 0) chk("extra_rd", 1, 0);
        else begin
          ri = exp_ri.pop_front(); rj = exp_rj.pop_front();
          chk("rd_i", rd_i, ri);
          chk("rd_j", rd_j, rj);
          chk("a_addr", char_a_addr, (ri == 0) ? 0 : ri - 1);
          chk("b_addr", char_b_addr, (rj == 0) ? 0 : rj - 1);
        end
      end
      if (out_valid) begin
        if (first_ov < 0) first_ov = cyc;
        chk("rd_in_emit", rd_en, 0);
        if (held) begin
          chk("hold_a", {gap_a, out_a}, {hv.ga, hv.a});
          chk("hold_b", {gap_b, out_b}, {hv.gb, hv.b});
        end else begin
          held = 1; hv.a = out_a; hv.ga = gap_a; hv.b = out_b; hv.gb = gap_b;
        end
      end
      if (done) begin
        seen = 1;
        break;
      end
      if (out_valid && stall > 0) begin
        out_ready = 1'b0; stall--;
      end else begin
        out_ready = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
      if (rnd) start = ($urandom_range(0, 7) == 0);
      if (out_valid && out_ready) begin
        last_xfer = cyc; held = 0;
        if (exp_cols.size() == 0) chk("extra_col", 1, 0);
        else begin
          got = exp_cols.pop_front();
          chk("col_a", {gap_a, out_a}, {got.ga, got.a});
          chk("col_b", {gap_b, out_b}, {got.gb, got.b});
        end
      end
    end
    start = 1'b0;
    if (!seen) chk("timeout", 1, 0);
    if (la == 0 && lb == 0) exp_done = 1;
    else if (e) exp_done = last_rd + 2;
    else exp_done = last_xfer + 1;
    chk("done_cycle", cyc, exp_done);
    if (la != 0 || lb != 0) chk("first_rd", first_rd, 1);
    if (ncols > 0) chk("first_ov", first_ov, 3);
    else chk("no_ov", first_ov, -1);
    chk("out_count", out_count, ncols);
    chk("err", err, e);
    chk("reads_left", exp_ri.size(), 0);
    chk("cols_left", exp_cols.size(), 0);
    @(negedge clk);
    chk("done_pulse", done, 0);
    chk("busy_idle", busy, 0);
  endtask

  initial begin
    int la, lb, nrd;
    rst_n = 1'b0; start = 1'b0; len_a = '0; len_b = '0; out_ready = 1'b1;
    clear_mems();
    #1;
    chk("rst_state", {rd_en, out_valid, out_a, gap_a, out_b, gap_b, busy, done, err, out_count}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // 1x1 diagonal
    sym_mem[1][1] = 3'b001; mem_a[0] = 2'b10; mem_b[0] = 2'b10;
    run(1, 1, 0, 0);

    // 2x0: forced ups, illegal symbols on column 0 must be ignored
    mem_a[0] = 2'b00; mem_a[1] = 2'b11; sym_mem[1][0] = 3'b011; sym_mem[2][0] = 3'b111;
    run(2, 0, 0, 0);

    // 2x2: up, left, diag
    sym_mem[2][2] = 3'b010; sym_mem[1][2] = 3'b100; sym_mem[1][1] = 3'b001;
    mem_a[0] = 2'b01; mem_a[1] = 2'b10; mem_b[0] = 2'b11; mem_b[1] = 2'b00;
    run(2, 2, 0, 0);
    run(2, 2, 5, 0);

    // illegal interior symbol, then a clean run clears err
    sym_mem[1][1] = 3'b011;
    run(1, 1, 0, 0);
    sym_mem[1][1] = 3'b001;
    run(1, 1, 0, 0);

    // empty traceback
    run(0, 0, 0, 0);

    // reset asserted in WAIT of the second step
    sym_mem[2][2] = 3'b010; sym_mem[1][2] = 3'b100;
    @(negedge clk);
    start = 1'b1; len_a = 7'd2; len_b = 7'd2;
    nrd = 0;
    for (int k = 0; k < 50 && nrd < 2; k++) begin
      @(negedge clk);
      start = 1'b0;
      if (rd_en) nrd++;
    end
    chk("rst_reach", nrd, 2);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_async", {rd_en, out_valid, out_a, gap_a, out_b, gap_b, busy, done, err, out_count}, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_idle", {busy, out_valid, rd_en}, 0);
    run(2, 2, 0, 0);

    // random matrices, lengths and backpressure
    for (int t = 0; t < 12; t++) begin
      la = $urandom_range(0, 12);
      lb = $urandom_range(0, 12);
      for (int r = 0; r < 13; r++) begin
        mem_a[r] = CHAR_W'($urandom);
        mem_b[r] = CHAR_W'($urandom);
        for (int c = 0; c < 13; c++) begin
          case ($urandom_range(0, 2))
            0: sym_mem[r][c] = 3'b001;
            1: sym_mem[r][c] = 3'b010;
            default: sym_mem[r][c] = 3'b100;
          endcase
          if ($urandom_range(0, 39) == 0) sym_mem[r][c] = 3'($urandom_range(0, 7));
        end
      end
      run(la, lb, 0, 1);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, miss);
    $finish;
  end

endmodule

// File: doc/nw_traceback.md
Name: nw_traceback

Overview:
- Needleman-Wunsch traceback engine, directly downstream of the max/score cell.
- Walks the stored direction-symbol matrix from cell (len_a, len_b) back to (0,0).
- Reads one symbol and one character pair per step from external single-port RAMs with 1-cycle read latency.
- Emits one aligned column per step, in reverse alignment order, over a valid/ready stream.

Parameters:
IDX_W, 7, width of row/column indices (max sequence length 2^IDX_W-1)
CHAR_W, 2, width of one sequence character (DNA base code)

Ports:
clk  in  1  single clock, all state on rising edge
rst_n  in  1  reset, asynchronous, active-low
start  in  1  one-cycle request to begin a traceback; honoured only in IDLE
len_a  in  IDX_W  length of sequence A (rows), sampled on accepted start
len_b  in  IDX_W  length of sequence B (columns), sampled on accepted start
rd_en  out  1  read strobe to symbol RAM and both character RAMs
rd_i  out  IDX_W  symbol row address (current i)
rd_j  out  IDX_W  symbol column address (current j)
char_a_addr  out  IDX_W  sequence A address = i-1 (0 when i=0)
char_b_addr  out  IDX_W  sequence B address = j-1 (0 when j=0)
rd_symbol  in  3  direction symbol: 3'b100 left, 3'b010 up, 3'b001 diag; valid the cycle after rd_en
char_a  in  CHAR_W  A character, valid the cycle after rd_en
char_b  in  CHAR_W  B character, valid the cycle after rd_en
out_valid  out  1  aligned column available
out_ready  in  1  consumer accepts column
out_a  out  CHAR_W  A character of column (0 when gap_a)
gap_a  out  1  column has a gap in A
out_b  out  CHAR_W  B character of column (0 when gap_b)
gap_b  out  1  column has a gap in B
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse at end of traceback
err  out  1  illegal symbol seen; sticky until next accepted start or reset
out_count  out  IDX_W+1  columns emitted in current/last traceback

Behaviour:
- Reset (async, rst_n=0): state IDLE, i=j=0. rd_en, out_valid, out_a, gap_a, out_b, gap_b, busy, done, err and out_count all 0. Takes effect immediately, including mid-traceback; the pending column is discarded.
- States: IDLE, READ, WAIT, EMIT, DONE.
- IDLE: on start=1, load i=len_a, j=len_b, clear err and out_count, then go to READ. If len_a=len_b=0, go directly to DONE.
- READ: rd_en=1 for exactly one cycle with rd_i=i, rd_j=j and the character addresses; then WAIT.
- WAIT: capture the move and data, then EMIT.
  - i=0 (j>0): move forced left; rd_symbol ignored.
  - j=0 (i>0): move forced up; rd_symbol ignored.
  - Otherwise, move = rd_symbol.
  - diag: out_a=char_a, out_b=char_b, both gap flags 0.
  - up: out_a=char_a, gap_b=1, out_b=0.
  - left: gap_a=1, out_a=0, out_b=char_b.
  - Illegal symbol (not one-hot, interior cell only): set err=1, emit nothing, go to DONE.
- EMIT: out_valid=1. Outputs stay stable until out_valid and out_ready are high in the same cycle (transfer). On transfer:
  - out_count+1.
  - Update indices: diag i-1, j-1; up i-1; left j-1.
  - If the new i=j=0, go to DONE; else go to READ.
  - out_valid drops the cycle after transfer.
- DONE: done=1 for one cycle, then IDLE. busy=0 in that following IDLE cycle.
- Latency:
  - Accepted start at edge 0 gives rd_en high in cycle 1 and out_valid high in cycle 3.
  - Minimum 3 cycles per column with out_ready held high.
  - Total columns lie between max(len_a,len_b) and len_a+len_b.
- start while busy is ignored; no queueing.
- Index arithmetic is unsigned. Indices never wrap: a decrement is never applied to a zero index because of the forced moves.

Test Plan:
- len_a=1, len_b=1, symbol(1,1)=3'b001, char_a=2'b10, char_b=2'b10, out_ready=1 -> rd_en in cycle 1; one column out_a=2'b10, out_b=2'b10 in cycle 3; done one cycle after transfer; out_count=1, err=0.
- len_a=2, len_b=0, chars A=[2'b00, 2'b11] -> two columns: first out_a=2'b11, gap_b=1; then out_a=2'b00, gap_b=1; symbols ignored; out_count=2.
- len_a=2, len_b=2, symbols (2,2)=3'b010, (1,2)=3'b100, (1,1)=3'b001 -> three columns: up, left, diag; read addresses (2,2), (1,2), (1,1) in that order; done; out_count=3.
- Same as the third test with out_ready held low 5 cycles during the first EMIT -> out_valid high and outputs stable all 5 cycles; no new rd_en until transfer; final outputs identical.
- len_a=1, len_b=1, symbol(1,1)=3'b011 -> err=1, no out_valid, done pulse; a following start clears err.
- Assert rst_n=0 in the WAIT of the second step -> all outputs 0 immediately (asynchronously); after release, IDLE, with a new start accepted normally.
